// File: rtl/rob_retire_if.sv
// rtl/rob_retire_if.sv - rename/execute/retire bundle for the rob_retire reorder buffer
interface rob_retire_if #(
  parameter int PREG_W = 7,
  parameter int IDX_W  = 4
);
  logic [1:0]             i_alloc_valid;
  logic [1:0][PREG_W-1:0] i_alloc_dst;
  logic [1:0][PREG_W-1:0] i_alloc_old_dst;
  logic                   o_alloc_ready;
  logic [1:0][IDX_W-1:0]  o_alloc_idx;
  logic [1:0]             i_cmpl_valid;
  logic [1:0][IDX_W-1:0]  i_cmpl_idx;
  logic [2:0]             o_retire_valid;
  logic [2:0][PREG_W-1:0] o_retire_dst;
  logic [2:0][PREG_W-1:0] o_retire_old_dst;
  logic [IDX_W:0]         o_count;

  modport master (
    output i_alloc_valid, i_alloc_dst, i_alloc_old_dst, i_cmpl_valid, i_cmpl_idx,
    input  o_alloc_ready, o_alloc_idx, o_retire_valid, o_retire_dst, o_retire_old_dst, o_count
  );

  modport slave (
    input  i_alloc_valid, i_alloc_dst, i_alloc_old_dst, i_cmpl_valid, i_cmpl_idx,
    output o_alloc_ready, o_alloc_idx, o_retire_valid, o_retire_dst, o_retire_old_dst, o_count
  );
endinterface

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - 2-wide allocate, 2-port complete, 3-wide in-order retire ROB
// Defining ROB_FLUSH_EN adds the i_flush input that empties the buffer in one edge.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int IDX_W  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef ROB_FLUSH_EN
  input  logic        i_flush,
`endif
  rob_retire_if.slave rob
);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0]             r_done;
  logic [DEPTH-1:0][PREG_W-1:0] r_dst;
  logic [DEPTH-1:0][PREG_W-1:0] r_old_dst;
  logic [IDX_W-1:0]             r_head;
  logic [IDX_W-1:0]             r_tail;
  logic [IDX_W:0]               r_count;
  logic [2:0]                   r_ret_valid;
  logic [2:0][PREG_W-1:0]       r_ret_dst;
  logic [2:0][PREG_W-1:0]       r_ret_old_dst;

  logic                         w_clr;
  logic                         w_ready;
  logic [IDX_W-1:0]             w_tail1;
  logic                         w_wr0_en;
  logic                         w_wr1_en;
  logic [PREG_W-1:0]            w_wr0_dst;
  logic [PREG_W-1:0]            w_wr0_old;
  logic [1:0]                   w_alloc_n;
  logic [2:0][IDX_W-1:0]        w_slot_idx;
  logic [2:0]                   w_slot_rdy;
  logic [2:0]                   w_ret_mask;
  logic [1:0]                   w_ret_n;

`ifdef ROB_FLUSH_EN
  assign w_clr = i_rst | i_flush;
`else
  assign w_clr = i_rst;
`endif

  assign w_tail1 = r_tail + IDX_W'(1);
  assign w_ready = (r_count <= (IDX_W+1)'(DEPTH - 2));

  assign rob.o_alloc_ready    = w_ready;
  assign rob.o_alloc_idx[0]   = r_tail;
  assign rob.o_alloc_idx[1]   = w_tail1;
  assign rob.o_count          = r_count;
  assign rob.o_retire_valid   = r_ret_valid;
  assign rob.o_retire_dst     = r_ret_dst;
  assign rob.o_retire_old_dst = r_ret_old_dst;

  // A lone lane-1 request is packed into the tail slot so the buffer stays contiguous.
  always_comb begin
    w_wr0_en  = w_ready & (|rob.i_alloc_valid);
    w_wr1_en  = w_ready & (&rob.i_alloc_valid);
    w_wr0_dst = rob.i_alloc_valid[0] ? rob.i_alloc_dst[0]     : rob.i_alloc_dst[1];
    w_wr0_old = rob.i_alloc_valid[0] ? rob.i_alloc_old_dst[0] : rob.i_alloc_old_dst[1];
    w_alloc_n = {w_wr1_en, w_wr0_en & ~w_wr1_en};
  end

  // Only registered done bits are examined, so a same-edge completion waits a cycle.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_slot_idx[k] = r_head + IDX_W'(k);
      w_slot_rdy[k] = r_valid[w_slot_idx[k]] & r_done[w_slot_idx[k]];
    end
    w_ret_mask[0] = w_slot_rdy[0];
    w_ret_mask[1] = w_slot_rdy[0] & w_slot_rdy[1];
    w_ret_mask[2] = w_slot_rdy[0] & w_slot_rdy[1] & w_slot_rdy[2];
    w_ret_n       = 2'(w_ret_mask[0]) + 2'(w_ret_mask[1]) + 2'(w_ret_mask[2]);
  end

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_valid       <= '0;
      r_done        <= '0;
      r_dst         <= '0;
      r_old_dst     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_ret_valid   <= '0;
      r_ret_dst     <= '0;
      r_ret_old_dst <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rob.i_cmpl_valid[p] && r_valid[rob.i_cmpl_idx[p]]) begin
          r_done[rob.i_cmpl_idx[p]] <= 1'b1;
        end
      end
      if (w_wr0_en) begin
        r_valid[r_tail]   <= 1'b1;
        r_done[r_tail]    <= 1'b0;
        r_dst[r_tail]     <= w_wr0_dst;
        r_old_dst[r_tail] <= w_wr0_old;
      end
      if (w_wr1_en) begin
        r_valid[w_tail1]   <= 1'b1;
        r_done[w_tail1]    <= 1'b0;
        r_dst[w_tail1]     <= rob.i_alloc_dst[1];
        r_old_dst[w_tail1] <= rob.i_alloc_old_dst[1];
      end
      for (int k = 0; k < 3; k++) begin
        if (w_ret_mask[k]) begin
          r_valid[w_slot_idx[k]] <= 1'b0;
          r_done[w_slot_idx[k]]  <= 1'b0;
        end
        r_ret_valid[k]   <= w_ret_mask[k];
        r_ret_dst[k]     <= w_ret_mask[k] ? r_dst[w_slot_idx[k]]     : '0;
        r_ret_old_dst[k] <= w_ret_mask[k] ? r_old_dst[w_slot_idx[k]] : '0;
      end
      r_head  <= r_head + IDX_W'(w_ret_n);
      r_tail  <= r_tail + IDX_W'(w_alloc_n);
      r_count <= r_count + (IDX_W+1)'(w_alloc_n) - (IDX_W+1)'(w_ret_n);
    end
  end

endmodule
